// File: rtl/if_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_id_stage                                                |
// | Brief   : Fetch stage and IF/ID pipeline register. Issues reads to a |
// |           1-cycle synchronous instruction ROM, pairs each returned   |
// |           word with its PC, and holds in-flight fetches in a small   |
// |           FIFO skid buffer while decode stalls.                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module if_id_stage #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              inst_ce_in,
   output logic              imem_ce,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              id_stall,
   input  logic              flush,
   output logic              if_stall,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_inst
);

   localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);

   // In-flight ROM request
   logic              r_req_v;
   logic [ADDR_W-1:0] r_req_pc;

   // Skid buffer: entry 0 is always the head, entries shift down on pop
   logic [c_CNT_W-1:0] r_count;
   logic [ADDR_W-1:0]  r_buf_pc   [BUF_DEPTH];
   logic [DATA_W-1:0]  r_buf_inst [BUF_DEPTH];

   // Decode-stage register
   logic              r_id_valid;
   logic [ADDR_W-1:0] r_id_pc;
   logic [DATA_W-1:0] r_id_inst;

   logic               w_busy;
   logic               w_issue;
   logic               w_arrive;
   logic               w_push;
   logic               w_pop;
   logic [c_CNT_W-1:0] w_wr_idx;

   // Buffer occupancy is the only source of if_stall, so the PC stage
   // never sees a combinational path from id_stall.
   assign w_busy   = (r_count != '0);
   assign w_issue  = inst_ce_in & ~w_busy & ~flush;
   assign w_arrive = r_req_v & ~flush;

   // An arriving word bypasses the buffer only when decode is free and
   // nothing older is waiting; otherwise it joins the tail.
   assign w_push   = w_arrive & (id_stall | w_busy);
   assign w_pop    = ~flush & ~id_stall & w_busy;
   // When popping in the same cycle the tail slides down by one.
   assign w_wr_idx = w_pop ? (r_count - c_CNT_W'(1)) : r_count;

   assign imem_ce   = w_issue;
   assign imem_addr = pc_in;
   assign if_stall  = w_busy;
   assign id_valid  = r_id_valid;
   assign id_pc     = r_id_pc;
   assign id_inst   = r_id_inst;

   // Track the single outstanding ROM read; flush cancels it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req_v  <= 1'b0;
         r_req_pc <= '0;
      end else begin
         r_req_v  <= w_issue;
         r_req_pc <= pc_in;
      end
   end

   // Buffer occupancy counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   generate
      for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_entry
         if (i < BUF_DEPTH - 1) begin : g_shift
            // Entry with a successor: take new word, else shift on pop.
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  r_buf_pc[i]   <= '0;
                  r_buf_inst[i] <= '0;
               end else if (w_push && (w_wr_idx == c_CNT_W'(i))) begin
                  r_buf_pc[i]   <= r_req_pc;
                  r_buf_inst[i] <= imem_rdata;
               end else if (w_pop) begin
                  r_buf_pc[i]   <= r_buf_pc[i+1];
                  r_buf_inst[i] <= r_buf_inst[i+1];
               end
            end
         end else begin : g_last
            // Last entry: only ever written from the ROM side.
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  r_buf_pc[i]   <= '0;
                  r_buf_inst[i] <= '0;
               end else if (w_push && (w_wr_idx == c_CNT_W'(i))) begin
                  r_buf_pc[i]   <= r_req_pc;
                  r_buf_inst[i] <= imem_rdata;
               end
            end
         end
      end
   endgenerate

   // Decode register: flush kills, stall holds, buffer head has priority
   // over the arriving word to keep program order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_id_valid <= 1'b0;
         r_id_pc    <= '0;
         r_id_inst  <= '0;
      end else if (flush) begin
         r_id_valid <= 1'b0;
      end else if (id_stall) begin
         r_id_valid <= r_id_valid;
      end else if (w_busy) begin
         r_id_valid <= 1'b1;
         r_id_pc    <= r_buf_pc[0];
         r_id_inst  <= r_buf_inst[0];
      end else if (w_arrive) begin
         r_id_valid <= 1'b1;
         r_id_pc    <= r_req_pc;
         r_id_inst  <= imem_rdata;
      end else begin
         r_id_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_if_id_stage                                             |
// | Brief   : Self-checking bench for if_id_stage: directed scenarios    |
// |           followed by random stall/flush traffic against a queue-    |
// |           based reference model.                                     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        inst_ce_in;
   logic        imem_ce;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        flush;
   logic        if_stall;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic        m_req_v;
   logic [31:0] m_req_pc;
   logic [31:0] m_buf[$];
   logic        m_id_v;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_inst;
   logic [31:0] g_target;

   if_id_stage #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .BUF_DEPTH(2)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .pc_in     (pc_in),
      .inst_ce_in(inst_ce_in),
      .imem_ce   (imem_ce),
      .imem_addr (imem_addr),
      .imem_rdata(imem_rdata),
      .id_stall  (id_stall),
      .flush     (flush),
      .if_stall  (if_stall),
      .id_valid  (id_valid),
      .id_pc     (id_pc),
      .id_inst   (id_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000 + (a >> 2);
   endfunction

   // Synchronous ROM with one cycle of read latency
   always @(posedge clk) begin
      if (imem_ce) imem_rdata <= rom_word(imem_addr);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_req_v   = 1'b0;
      m_req_pc  = '0;
      m_buf.delete();
      m_id_v    = 1'b0;
      m_id_pc   = '0;
      m_id_inst = '0;
   endtask

   task automatic model_step(input logic [31:0] pc, input logic ce,
                             input logic st, input logic fl);
      logic busy, issue, arrive;
      busy   = (m_buf.size() != 0);
      issue  = ce && !busy && !fl;
      arrive = m_req_v && !fl;
      if (fl) begin
         m_buf.delete();
         m_id_v = 1'b0;
      end else if (st) begin
         if (arrive) m_buf.push_back(m_req_pc);
      end else if (busy) begin
         m_id_pc   = m_buf.pop_front();
         m_id_inst = rom_word(m_id_pc);
         m_id_v    = 1'b1;
         if (arrive) m_buf.push_back(m_req_pc);
      end else if (arrive) begin
         m_id_pc   = m_req_pc;
         m_id_inst = rom_word(m_req_pc);
         m_id_v    = 1'b1;
      end else begin
         m_id_v = 1'b0;
      end
      m_req_v  = issue;
      m_req_pc = pc;
   endtask

   task automatic compare_state();
      check("id_valid", id_valid, m_id_v);
      check("id_pc", id_pc, m_id_pc);
      check("id_inst", id_inst, m_id_inst);
      check("if_stall", if_stall, (m_buf.size() != 0));
      check("count", u_dut.r_count, m_buf.size());
   endtask

   // One clock: check combinational fetch outputs, clock, update model,
   // compare registered outputs, then advance the PC generator.
   task automatic tick();
      logic [31:0] s_pc;
      logic        s_ce, s_st, s_fl, s_busy;
      #1;
      s_busy = (m_buf.size() != 0);
      check("imem_ce", imem_ce, inst_ce_in && !s_busy && !flush);
      check("imem_addr", imem_addr, pc_in);
      s_pc = pc_in;
      s_ce = inst_ce_in;
      s_st = id_stall;
      s_fl = flush;
      @(posedge clk);
      #1;
      if (!rst) model_reset();
      else      model_step(s_pc, s_ce, s_st, s_fl);
      compare_state();
      if (s_fl)         pc_in = g_target;
      else if (!s_busy) pc_in = pc_in + 32'd4;
      inst_ce_in = (pc_in < 32'h400);
   endtask

   initial begin
      logic [31:0] exp_seq [3];
      int          got;

      rst        = 1'b0;
      pc_in      = '0;
      inst_ce_in = 1'b1;
      id_stall   = 1'b0;
      flush      = 1'b0;
      g_target   = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_state();
      rst = 1'b1;

      // Free run: pc 0 reaches decode two edges later
      tick();
      tick();
      check("t1_valid", id_valid, 1);
      check("t1_pc", id_pc, 32'h0);
      check("t1_inst", id_inst, 32'h1000);
      tick();
      tick();

      // Stall three cycles while pc_in = 0x10
      check("t2_pc_before", pc_in, 32'h10);
      id_stall = 1'b1;
      repeat (3) tick();
      check("t2_hold_pc", id_pc, 32'h08);
      check("t2_count", u_dut.r_count, 2);
      check("t2_if_stall", if_stall, 1);
      id_stall = 1'b0;
      exp_seq[0] = 32'h0C;
      exp_seq[1] = 32'h10;
      exp_seq[2] = 32'h14;
      got = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (id_valid && got < 3) begin
            check("t2_seq", id_pc, exp_seq[got]);
            got++;
         end
      end
      check("t2_delivered", got, 3);

      // Flush with a buffered entry and a read in flight, under stall
      id_stall = 1'b1;
      tick();
      check("t3_count_pre", u_dut.r_count, 1);
      check("t3_req_v_pre", u_dut.r_req_v, 1);
      flush    = 1'b1;
      g_target = 32'h100;
      tick();
      flush    = 1'b0;
      id_stall = 1'b0;
      check("t3_valid", id_valid, 0);
      check("t3_count", u_dut.r_count, 0);
      check("t3_if_stall", if_stall, 0);
      tick();
      tick();
      check("t3_valid_new", id_valid, 1);
      check("t3_pc_new", id_pc, 32'h100);

      // Run off the end of fetchable space
      flush    = 1'b1;
      g_target = 32'h3F4;
      tick();
      flush = 1'b0;
      repeat (6) tick();
      check("t4_valid", id_valid, 0);
      check("t4_pc", id_pc, 32'h3FC);
      check("t4_inst", id_inst, 32'h10FF);
      check("t4_imem_ce", imem_ce, 0);

      // Asynchronous reset mid-cycle with a buffered entry and live ID
      flush    = 1'b1;
      g_target = 32'h40;
      tick();
      flush = 1'b0;
      tick();
      tick();
      id_stall = 1'b1;
      tick();
      check("t5_count_pre", u_dut.r_count, 1);
      check("t5_valid_pre", id_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      check("t5_valid", id_valid, 0);
      check("t5_pc", id_pc, 0);
      check("t5_inst", id_inst, 0);
      check("t5_if_stall", if_stall, 0);
      check("t5_count", u_dut.r_count, 0);
      model_reset();
      id_stall = 1'b0;
      tick();
      rst        = 1'b1;
      pc_in      = 32'h80;
      inst_ce_in = 1'b1;
      tick();
      check("t5_no_stale", id_valid, 0);
      tick();
      check("t5_pc_after", id_pc, 32'h80);
      check("t5_valid_after", id_valid, 1);

      // Random stall / flush traffic
      for (int k = 0; k < 10000; k++) begin
         id_stall = (($urandom % 4) == 0);
         flush    = (($urandom % 25) == 0);
         g_target = {20'd0, 10'($urandom_range(0, 32'h10F)), 2'b00};
         tick();
      end
      id_stall = 1'b0;
      flush    = 1'b0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
